// File: rtl/sprite_drawer.sv
// Sprite blitter: walks a SPRITE_W x SPRITE_H window, fetching each pixel from the
// character or background ROM and plotting it to the VGA adapter with screen clipping.
module sprite_drawer #(
  parameter int         SPRITE_W    = 8,
  parameter int         SPRITE_H    = 8,
  parameter logic [8:0] TRANSPARENT = 9'h000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        drawChar,
  input  logic        drawBG,
  input  logic [8:0]  xCoordinate,
  input  logic [7:0]  yCoordinate,
  output logic [9:0]  char_addr,
  input  logic [8:0]  char_data,
  output logic [16:0] bg_addr,
  input  logic [8:0]  bg_data,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [8:0]  colour,
  output logic        plot,
  output logic        doneChar,
  output logic        doneBG
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLOT,
    S_DONE,
    S_RELEASE
  } state_t;

  localparam logic [4:0] LAST_I    = 5'(SPRITE_W - 1);
  localparam logic [4:0] LAST_J    = 5'(SPRITE_H - 1);
  localparam logic       MODE_BG   = 1'b0;
  localparam logic       MODE_CHAR = 1'b1;

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_i;
  logic [4:0]  r_j;
  logic [8:0]  r_x0;
  logic [7:0]  r_y0;
  logic        r_mode;
  logic [8:0]  r_vga_x;
  logic [7:0]  r_vga_y;
  logic [8:0]  r_colour;

  logic [9:0]  w_px;
  logic [8:0]  w_py;
  logic        w_clip;
  logic        w_transp;
  logic        w_last_pix;
  logic [8:0]  w_pix_colour;

  // Screen position is computed one bit wider than the VGA ports so edges never wrap.
  assign w_px         = {1'b0, r_x0} + {5'b0, r_i};
  assign w_py         = {1'b0, r_y0} + {4'b0, r_j};
  assign w_clip       = (w_px > 10'd319) || (w_py > 9'd239);
  assign w_pix_colour = (r_mode == MODE_CHAR) ? char_data : bg_data;
  assign w_transp     = (r_mode == MODE_CHAR) && (char_data == TRANSPARENT);
  assign w_last_pix   = (r_i == LAST_I) && (r_j == LAST_J);

  assign char_addr = {5'b0, r_j} * 10'(SPRITE_W) + {5'b0, r_i};
  assign bg_addr   = {8'b0, w_py} * 17'd320 + {7'b0, w_px};

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    plot         = 1'b0;
    doneChar     = 1'b0;
    doneBG       = 1'b0;
    vga_x        = r_vga_x;
    vga_y        = r_vga_y;
    colour       = r_colour;
    case (r_state)
      S_IDLE:  if (drawBG || drawChar) w_next_state = S_FETCH;
      S_FETCH: w_next_state = S_PLOT;
      S_PLOT: begin
        vga_x        = w_px[8:0];
        vga_y        = w_py[7:0];
        colour       = w_pix_colour;
        plot         = !w_clip && !w_transp;
        w_next_state = w_last_pix ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        doneBG       = (r_mode == MODE_BG);
        doneChar     = (r_mode == MODE_CHAR);
        w_next_state = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the requester to drop its line so the same request cannot retrigger.
        if ((r_mode == MODE_BG) ? !drawBG : !drawChar) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_i      <= '0;
      r_j      <= '0;
      r_x0     <= '0;
      r_y0     <= '0;
      r_mode   <= MODE_BG;
      r_vga_x  <= '0;
      r_vga_y  <= '0;
      r_colour <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (drawBG || drawChar) begin
            r_x0   <= xCoordinate;
            r_y0   <= yCoordinate;
            r_mode <= drawBG ? MODE_BG : MODE_CHAR;
            r_i    <= '0;
            r_j    <= '0;
          end
        end
        S_PLOT: begin
          r_vga_x  <= w_px[8:0];
          r_vga_y  <= w_py[7:0];
          r_colour <= w_pix_colour;
          if (r_i == LAST_I) begin
            r_i <= '0;
            r_j <= w_last_pix ? 5'd0 : r_j + 5'd1;
          end else begin
            r_i <= r_i + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_drawer.sv
// Scoreboard bench for sprite_drawer (8x8): ROM models, expected-pixel queue, done latency.
module tb_sprite_drawer;

  logic        clock = 1'b0;
  logic        resetn;
  logic        drawChar;
  logic        drawBG;
  logic [8:0]  xCoordinate;
  logic [7:0]  yCoordinate;
  logic [9:0]  char_addr;
  logic [8:0]  char_data;
  logic [16:0] bg_addr;
  logic [8:0]  bg_data;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [8:0]  colour;
  logic        plot;
  logic        doneChar;
  logic        doneBG;

  sprite_drawer #(.SPRITE_W(8), .SPRITE_H(8), .TRANSPARENT(9'h000)) dut (
    .clock(clock), .resetn(resetn), .drawChar(drawChar), .drawBG(drawBG),
    .xCoordinate(xCoordinate), .yCoordinate(yCoordinate),
    .char_addr(char_addr), .char_data(char_data),
    .bg_addr(bg_addr), .bg_data(bg_data),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
    .doneChar(doneChar), .doneBG(doneBG)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] c;
  } pix_t;

  pix_t        exp_q[$];
  logic [8:0]  char_rom [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          plot_cnt = 0;
  bit          first_seen = 0;
  bit          prev_plot  = 0;
  logic [8:0]  first_x, last_x;
  logic [7:0]  first_y, last_y;
  logic [16:0] first_bg;

  function automatic logic [8:0] bg_fn(input logic [16:0] a);
    return a[8:0] ^ {1'b0, a[16:9]};
  endfunction

  always @(posedge clock) begin
    char_data <= char_rom[char_addr];
    bg_data   <= bg_fn(bg_addr);
  end

  // Expected pixel stream for one draw, in raster order.
  task automatic push_model(input bit is_char, input int x0, input int y0);
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 8; i++) begin
        int px, py, a;
        logic [8:0] c;
        px = x0 + i;
        py = y0 + j;
        if (px > 319 || py > 239) continue;
        if (is_char) begin
          c = char_rom[j * 8 + i];
          if (c == 9'h000) continue;
        end else begin
          a = (py * 320 + px) % 131072;
          c = bg_fn(17'(a));
        end
        exp_q.push_back('{x: 9'(px), y: 8'(py), c: c});
      end
    end
  endtask

  always @(negedge clock) begin
    if (plot === 1'b1) begin
      pix_t e;
      plot_cnt++;
      if (!first_seen) begin
        first_seen = 1;
        first_x = vga_x; first_y = vga_y; first_bg = bg_addr;
      end
      last_x = vga_x; last_y = vga_y;
      n_checks++;
      if (prev_plot) begin
        n_fail++;
        $display("FAIL plot_consecutive: plot high two cycles in a row at x=%0d y=%0d", vga_x, vga_y);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%h, expected no plot", vga_x, vga_y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, colour} !== {e.x, e.y, e.c}) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d c=%h, expected x=%0d y=%0d c=%h",
                   vga_x, vga_y, colour, e.x, e.y, e.c);
        end
      end
    end
    prev_plot = (plot === 1'b1);
  end

  task automatic start_draw(input bit bg, input bit ch, input int x, input int y);
    @(negedge clock);
    xCoordinate = 9'(x);
    yCoordinate = 8'(y);
    drawBG      = bg;
    drawChar    = ch;
    plot_cnt    = 0;
    first_seen  = 0;
  endtask

  // Counts negedges until the wanted done pulse; the other done must stay low.
  task automatic wait_done(input bit want_bg, output int lat);
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clock);
      if ((want_bg ? doneChar : doneBG) !== 1'b0) begin
        n_checks++; n_fail++;
        $display("FAIL wrong_done: got doneBG=%b doneChar=%b, expected only %s", doneBG, doneChar,
                 want_bg ? "doneBG" : "doneChar");
      end
      if ((want_bg ? doneBG : doneChar) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_draw(input string name, input int lat, input int lat_exp, input int plots_exp);
    n_checks++;
    if (lat !== lat_exp) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, expected %0d", name, lat, lat_exp);
    end
    n_checks++;
    if (plot_cnt !== plots_exp) begin
      n_fail++;
      $display("FAIL %s_plots: got %0d, expected %0d", name, plot_cnt, plots_exp);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d expected pixels never plotted, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; drawBG = 1'b0; drawChar = 1'b0;
    xCoordinate = 9'd5; yCoordinate = 8'd7;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({plot, doneChar, doneBG} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got plot/doneChar/doneBG=%b, expected 000", {plot, doneChar, doneBG});
    end
    n_checks++;
    if ({vga_x, vga_y, colour} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%h, expected 0 0 000", vga_x, vga_y, colour);
    end
    n_checks++;
    if ({char_addr, bg_addr} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got char_addr=%0d bg_addr=%0d, expected 0 0", char_addr, bg_addr);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_bg_full();
    int lat;
    start_draw(1, 0, 95, 221);
    push_model(0, 95, 221);
    wait_done(1, lat);
    drawBG = 1'b0;
    check_draw("bg_full", lat, 129, 64);
    n_checks++;
    if ({first_x, first_y, last_x, last_y} !== {9'd95, 8'd221, 9'd102, 8'd228}) begin
      n_fail++;
      $display("FAIL bg_full_corners: got first (%0d,%0d) last (%0d,%0d), expected (95,221) (102,228)",
               first_x, first_y, last_x, last_y);
    end
    n_checks++;
    if (first_bg !== 17'd70815) begin
      n_fail++;
      $display("FAIL bg_full_addr: got %0d, expected 70815", first_bg);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_char_transparent();
    int lat;
    start_draw(0, 1, 126, 68);
    push_model(1, 126, 68);
    wait_done(0, lat);
    drawChar = 1'b0;
    check_draw("char_transp", lat, 129, 54);
    repeat (3) @(negedge clock);
  endtask

  task automatic test_clip();
    int lat;
    start_draw(1, 0, 316, 236);
    push_model(0, 316, 236);
    wait_done(1, lat);
    drawBG = 1'b0;
    check_draw("clip", lat, 129, 16);
    n_checks++;
    if ({first_x, first_y, last_x, last_y} !== {9'd316, 8'd236, 9'd319, 8'd239}) begin
      n_fail++;
      $display("FAIL clip_corners: got first (%0d,%0d) last (%0d,%0d), expected (316,236) (319,239)",
               first_x, first_y, last_x, last_y);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_both_requests();
    int lat;
    start_draw(1, 1, 10, 20);
    push_model(0, 10, 20);
    wait_done(1, lat);
    check_draw("both_bg", lat, 129, 64);
    // RELEASE, then one IDLE cycle, then the char draw starts.
    drawBG     = 1'b0;
    plot_cnt   = 0;
    first_seen = 0;
    push_model(1, 10, 20);
    wait_done(0, lat);
    drawChar = 1'b0;
    check_draw("both_char", lat, 131, 54);
    repeat (3) @(negedge clock);
  endtask

  task automatic test_hold_after_done();
    int lat;
    start_draw(0, 1, 200, 100);
    push_model(1, 200, 100);
    wait_done(0, lat);
    check_draw("hold", lat, 129, 54);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      n_checks++;
      if ({doneChar, doneBG, plot} !== 3'b000) begin
        n_fail++;
        $display("FAIL hold_retrigger: cycle %0d got doneChar/doneBG/plot=%b, expected 000", k,
                 {doneChar, doneBG, plot});
      end
    end
    drawChar = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_abort();
    int lat;
    start_draw(0, 1, 40, 30);
    push_model(1, 40, 30);
    repeat (41) @(negedge clock);
    resetn = 1'b0;
    n_checks++;
    if (plot_cnt !== 16) begin
      n_fail++;
      $display("FAIL abort_partial: got %0d plots before reset, expected 16", plot_cnt);
    end
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_checks++;
      if ({plot, doneChar, doneBG} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_quiet: cycle %0d got plot/doneChar/doneBG=%b, expected 000", k,
                 {plot, doneChar, doneBG});
      end
    end
    plot_cnt   = 0;
    first_seen = 0;
    push_model(1, 40, 30);
    resetn = 1'b1;
    wait_done(0, lat);
    drawChar = 1'b0;
    check_draw("abort_redraw", lat, 129, 54);
    repeat (3) @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) char_rom[k] = (k < 64) ? 9'(k * 7 + 3) : 9'h000;
    char_rom[0]  = 9'h000; char_rom[5]  = 9'h000; char_rom[9]  = 9'h000;
    char_rom[18] = 9'h000; char_rom[27] = 9'h000; char_rom[33] = 9'h000;
    char_rom[40] = 9'h000; char_rom[51] = 9'h000; char_rom[60] = 9'h000;
    char_rom[63] = 9'h000;
    test_reset();
    test_bg_full();
    test_char_transparent();
    test_clip();
    test_both_requests();
    test_hold_after_done();
    test_reset_abort();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d pixels left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
